// File: rtl/mux_test_pkg.sv
// Shared types and constants for the mux characterisation sequencer.
// Register offsets are byte addresses; the slave decodes bits [3:2].
package mux_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int VEC_W = 6;

  localparam logic [3:0] CTRL       = 4'h0;
  localparam logic [3:0] STATUS     = 4'h4;
  localparam logic [3:0] ERR_COUNT  = 4'h8;
  localparam logic [3:0] FIRST_FAIL = 4'hC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_LOOP_BIT   = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_PASS_BIT   = 2;
  localparam int STAT_PASSES_LSB = 8;
  localparam int FF_GF_BIT       = 8;
  localparam int FF_BFG_BIT      = 9;
  localparam int FF_VALID_BIT    = 31;

  // Ideal 4:1 mux for a vector: selects are vec[5:4], data inputs vec[3:0].
  function automatic logic ideal_mux(input logic [VEC_W-1:0] vec);
    logic [3:0] data;
    data = vec[3:0];
    return data[vec[5:4]];
  endfunction

endpackage

// File: rtl/mux_test_sync.sv
// Two-flop synchroniser for the asynchronous pad returns of the mux under test.
module mux_test_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_test_sequencer.sv
// Sweeps all 64 mux vectors, checks gf/bfg against the ideal mux, exposes results over Wishbone.
// Define MUX_TEST_LOOP_EN to implement CTRL.LOOP (repeating sweeps).
module mux_test_sequencer
  import mux_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  mux_i,
  output logic [1:0]  mux_s,
  input  logic        gf_out_i,
  input  logic        bfg_out_i,
  output logic        done_irq
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t state, next_state;

  logic [VEC_W-1:0]     vec;
  logic [7:0]           settle_cnt;
  logic [ERR_CNT_W-1:0] err_count;
  logic [7:0]           passes;
  logic                 done_flag;
  logic                 ff_valid, ff_gf_bad, ff_bfg_bad;
  logic [VEC_W-1:0]     ff_index;
  logic                 loop_en;
  logic                 start_req;
  logic [1:0]           pad_sync;
  logic                 busy, start_go, do_apply, do_settle, do_check;
  logic                 last_vec, exp_bit, gf_bad, bfg_bad;
  logic                 wb_access;
  logic [31:0]          rd_data;
  logic                 unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  mux_test_sync #(.WIDTH(2)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   ({gf_out_i, bfg_out_i}),
    .q   (pad_sync)
  );

  assign last_vec = (vec == '1);
  assign exp_bit  = ideal_mux(vec);
  assign gf_bad   = (pad_sync[1] != exp_bit);
  assign bfg_bad  = (pad_sync[0] != exp_bit);
  assign done_irq = done_flag;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_req) next_state = ST_APPLY;
      ST_APPLY:  next_state = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 8'd0) next_state = ST_CHECK;
      ST_CHECK:  next_state = (last_vec && !loop_en) ? ST_DONE : ST_APPLY;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    start_go  = (state == ST_IDLE) && start_req;
    do_apply  = (state == ST_APPLY);
    do_settle = (state == ST_SETTLE);
    do_check  = (state == ST_CHECK);
  end

  // Sweep datapath: vector stepping, settle timing and result accumulation.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      vec        <= '0;
      mux_i      <= '0;
      mux_s      <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      passes     <= '0;
      done_flag  <= 1'b0;
      ff_valid   <= 1'b0;
      ff_gf_bad  <= 1'b0;
      ff_bfg_bad <= 1'b0;
      ff_index   <= '0;
    end else begin
      if (start_go) begin
        vec        <= '0;
        err_count  <= '0;
        passes     <= '0;
        done_flag  <= 1'b0;
        ff_valid   <= 1'b0;
        ff_gf_bad  <= 1'b0;
        ff_bfg_bad <= 1'b0;
        ff_index   <= '0;
      end
      if (do_apply) begin
        mux_i      <= vec[3:0];
        mux_s      <= vec[5:4];
        settle_cnt <= SETTLE_LOAD;
      end
      if (do_settle) settle_cnt <= settle_cnt - 8'd1;
      if (do_check) begin
        if (gf_bad || bfg_bad) begin
          if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          if (!ff_valid) begin
            ff_valid   <= 1'b1;
            ff_gf_bad  <= gf_bad;
            ff_bfg_bad <= bfg_bad;
            ff_index   <= vec;
          end
        end
        if (last_vec) begin
          if (passes != 8'hFF) passes <= passes + 8'd1;
          if (!loop_en) done_flag <= 1'b1;
        end
        vec <= vec + VEC_W'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[3:2])
      CTRL[3:2]:      rd_data[CTRL_LOOP_BIT] = loop_en;
      STATUS[3:2]: begin
        rd_data[STAT_BUSY_BIT] = busy;
        rd_data[STAT_DONE_BIT] = done_flag;
        rd_data[STAT_PASS_BIT] = (passes != 8'd0) && (err_count == '0);
        rd_data[STAT_PASSES_LSB +: 8] = passes;
      end
      ERR_COUNT[3:2]: rd_data[ERR_CNT_W-1:0] = err_count;
      default: begin
        rd_data[FF_VALID_BIT]  = ff_valid;
        rd_data[FF_BFG_BIT]    = ff_bfg_bad;
        rd_data[FF_GF_BIT]     = ff_gf_bad;
        rd_data[VEC_W-1:0]     = ff_index;
      end
    endcase
  end

  // Single-cycle ack; a held strobe is not acknowledged twice in a row.
  assign wb_access = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      start_req <= 1'b0;
    end else begin
      wbs_ack_o <= wb_access;
      wbs_dat_o <= (wb_access && !wbs_we_i) ? rd_data : 32'd0;
      start_req <= wb_access && wbs_we_i && (wbs_adr_i[3:2] == CTRL[3:2])
                   && wbs_dat_i[CTRL_START_BIT];
    end
  end

`ifdef MUX_TEST_LOOP_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      loop_en <= 1'b0;
    else if (wb_access && wbs_we_i && (wbs_adr_i[3:2] == CTRL[3:2]))
      loop_en <= wbs_dat_i[CTRL_LOOP_BIT];
  end
`else
  assign loop_en = 1'b0;
`endif

endmodule

// File: doc/mux_test_sequencer.md
# mux_test_sequencer

On-chip stimulus and checker for the mux characterisation experiment. It drives the four data inputs and two selects of the mux under test, sweeping all 64 combinations. It samples the two candidate outputs (`gf_out`, `bfg_out`) and compares each against the ideal 4:1 mux result, counting mismatches. Control and results are exposed to the management SoC as a Wishbone slave in the user project wrapper, next to the mux under test.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles between applying a vector and sampling the outputs. Legal range 3..255, because it must cover the synchroniser latency.
- `ERR_CNT_W`, default 16: width of the mismatch counter.

Ports:
- `wb_clk_i`  in  1  the only clock
- `wb_rst_i`  in  1  reset, synchronous and active-high
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write-enable
- `wbs_sel_i`  in  4  byte selects, ignored; all writes are full-word
- `wbs_adr_i`  in  32  address; only bits [3:2] are decoded
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  access acknowledge
- `wbs_dat_o`  out  32  read data
- `mux_i`  out  4  data inputs to the mux under test (pads i0..i3)
- `mux_s`  out  2  selects to the mux under test (pads s0, s1)
- `gf_out_i`, `bfg_out_i`  in  1 each  mux outputs returned from the pads; asynchronous
- `done_irq`  out  1  high while the DONE status bit is set

## Operation
Register map, decoded on `wbs_adr_i[3:2]`:
- 0x0 CTRL
  - bit0 START: write 1 to start; reads 0.
  - bit1 LOOP: read/write.
- 0x4 STATUS, read-only
  - bit0 BUSY
  - bit1 DONE
  - bit2 PASS, meaning the mismatch count is 0
  - [15:8] PASSES: completed sweeps, saturating at 255
- 0x8 ERR_COUNT, read-only: mismatches, saturating at all-ones.
- 0xC FIRST_FAIL, read-only
  - bit31 VALID
  - bit9 BFG_BAD, bit8 GF_BAD
  - [5:0] index of the first failing vector

Vector encoding:
- Index `vec[5:0]`, with `mux_s = vec[5:4]` and `mux_i = vec[3:0]`.
- Expected output is `exp = mux_i[mux_s]`.

State machine:
- IDLE → APPLY on START. START clears ERR_COUNT, FIRST_FAIL, DONE and PASSES, and sets `vec = 0`. START is ignored while BUSY.
- APPLY, 1 cycle: registers `mux_i`/`mux_s` from `vec` and loads the settle counter.
- SETTLE, `SETTLE_CYCLES` cycles.
- CHECK, 1 cycle: compares the synchronised `gf` and `bfg` against `exp`.
  - A mismatch is `gf != exp` or `bfg != exp`, and adds 1 to ERR_COUNT once per vector.
  - The first mismatch latches FIRST_FAIL.
  - If `vec == 63`: increment PASSES, then go to DONE. With LOOP enabled, go to APPLY instead, wrapping `vec` to 0.
  - Otherwise increment `vec` and go to APPLY.
- DONE: sets DONE, clears BUSY, and returns to IDLE the next cycle. DONE stays set until the next START.
- BUSY = state ∉ {IDLE, DONE}.

## Timing
- Reset values:
  - `mux_i = 0`, `mux_s = 0`
  - `wbs_ack_o = 0`, `wbs_dat_o = 0`, `done_irq = 0`
  - all registers 0, state IDLE
- Reset mid-sweep aborts immediately: nothing is preserved and outputs return to their reset values.
- Wishbone:
  - `wbs_ack_o` pulses for one cycle, the cycle after `stb & cyc` is sampled with `ack` low.
  - No access is acknowledged on back-to-back cycles; the master must drop `stb`.
  - `wbs_dat_o` is valid with `ack` and is 0 otherwise.
  - The FSM leaves IDLE on the cycle after the START write is acknowledged.
- `gf_out_i`/`bfg_out_i` pass through a 2-flop synchroniser. CHECK therefore observes pad values from at least `SETTLE_CYCLES - 2` cycles after APPLY.
- Per vector: `SETTLE_CYCLES + 2` cycles. A full sweep takes `64 × (SETTLE_CYCLES + 2)` cycles, which is 384 at the default.
- Simultaneous events:
  - A START write in the same cycle DONE is entered is ignored.
  - A STATUS read in that same cycle returns pre-update values.
- Counter widths: ERR_COUNT is `ERR_CNT_W` bits, zero-extended to 32 on read.

## Configuration
- `MUX_TEST_LOOP_EN` defined:
  - CTRL.LOOP is implemented.
  - Sweeps repeat until LOOP is written to 0; the current sweep then completes and DONE is entered.
  - PASSES counts every sweep.
- `MUX_TEST_LOOP_EN` undefined:
  - CTRL.LOOP is not stored; writes are ignored and it reads 0.
  - Each START produces exactly one sweep; PASSES is 0 or 1.

## Structure
- Package `mux_test_pkg` holds:
  - the state enum
  - register offsets (`CTRL`, `STATUS`, `ERR_COUNT`, `FIRST_FAIL`)
  - field bit positions
  - the vector width constant (6)
- Sub-module `mux_test_sync` is a 2-flop synchroniser, with a width parameter, instantiated once for {gf, bfg}.
- The FSM, counters and Wishbone slave live in the top module.

## Test plan
- Both outputs driven by an ideal mux model; write START → BUSY clears and DONE/`done_irq` assert 384 cycles later, ERR_COUNT = 0, PASS = 1, FIRST_FAIL = 0.
- `bfg_out_i` tied 0, gf ideal → ERR_COUNT = 32, FIRST_FAIL = 0x8000_0201 (vec 1, BFG_BAD).
- `gf_out_i` = inverted ideal, bfg ideal → ERR_COUNT = 64, FIRST_FAIL = 0x8000_0100.
- Assert `wb_rst_i` for one cycle at vector 20 → the next cycle shows `mux_i = 0`, `mux_s = 0`, and STATUS/ERR_COUNT read 0.
- START written again while BUSY → ignored; the sweep still ends at cycle 384. A STATUS read mid-run returns BUSY = 1 with `wbs_ack_o` high for exactly one cycle.
- With `MUX_TEST_LOOP_EN`: LOOP = 1 with START, then clear LOOP during the third sweep → DONE after sweep 3, PASSES = 3, ERR_COUNT = 0.
